// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/ext/cond constants,
// flag bit positions and the writeback classifier.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDecode  = 2'd1,
    StExecute = 2'd2,
    StHalt    = 2'd3
  } state_e;

  localparam logic [3:0] OpRtype = 4'b0000;
  localparam logic [3:0] OpBcond = 4'b1100;
  localparam logic [3:0] OpHalt  = 4'b1110;
  localparam logic [3:0] OpCmpi  = 4'b1011;

  localparam logic [3:0] ExtCmp = 4'b1011;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondUc = 4'b1110;

  localparam int unsigned FlagC = 4;
  localparam int unsigned FlagL = 3;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagN = 0;

  // Compares, branches and halt leave the register file untouched.
  function automatic logic has_writeback(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    if (op == OpBcond || op == OpHalt || op == OpCmpi) return 1'b0;
    if (op == OpRtype && ir[7:4] == ExtCmp) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against the latched flag register.
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flag_reg_i,
  output logic       taken_o
);

  logic unused_flags;
  assign unused_flags = ^{flag_reg_i[FlagL], flag_reg_i[FlagF], flag_reg_i[FlagN]};

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CondEq:  taken_o = flag_reg_i[FlagZ];
      CondNe:  taken_o = ~flag_reg_i[FlagZ];
      CondCs:  taken_o = flag_reg_i[FlagC];
      CondCc:  taken_o = ~flag_reg_i[FlagC];
      CondUc:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute control unit: owns IR, PC and flag register, and drives the
// datapath's register enables and operand selects.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr_in,
  input  logic                instr_valid,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [4:0]          Flags,
  output logic [4:0]          flag_reg,
  output logic [15:0]         RegEnable,
  output logic [3:0]          MuxControlA,
  output logic [3:0]          MuxControlB,
  output logic                MuxControlC,
  output logic [15:0]         AluControl,
  output logic                halted
);

  state_e              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]          flag_reg_q, flag_reg_d;

  logic [3:0]          opcode;
  logic                taken;
  logic [PC_WIDTH-1:0] branch_off;

  assign opcode     = ir_q[15:12];
  assign branch_off = {{(PC_WIDTH-8){ir_q[7]}}, ir_q[7:0]};

  branch_cond_eval u_branch_cond_eval (
    .cond_i     (ir_q[11:8]),
    .flag_reg_i (flag_reg_q),
    .taken_o    (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      ir_q       <= '0;
      pc_q       <= RESET_PC;
      flag_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      flag_reg_q <= flag_reg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    flag_reg_d = flag_reg_q;
    instr_req  = 1'b0;
    halted     = 1'b0;
    RegEnable  = '0;
    case (state_q)
      StFetch: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = (opcode == OpHalt) ? StHalt : StExecute;
      end
      StExecute: begin
        if (has_writeback(ir_q)) RegEnable = 16'(1) << ir_q[11:8];
        if (opcode == OpBcond) begin
          // Branch target is relative to the branch's own pc.
          pc_d = taken ? (pc_q + branch_off) : (pc_q + 1'b1);
        end else begin
          pc_d       = pc_q + 1'b1;
          flag_reg_d = Flags;
        end
        state_d = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign pc          = pc_q;
  assign flag_reg    = flag_reg_q;
  assign AluControl  = ir_q;
  assign MuxControlA = ir_q[11:8];
  assign MuxControlB = ir_q[3:0];
  assign MuxControlC = (opcode != OpRtype);

endmodule
